// File: rtl/rd_req_arb.sv
// Read-request arbiter: round-robin grant of per-requester read requests,
// one large downstream request per grant, and in-order completion tracking
// of downstream R bursts through an order FIFO.
module rd_req_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ORDER_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_len,
  output logic                          dn_start_valid,
  input  logic                          dn_start_ready,
  output logic [ADDR_WIDTH-1:0]         dn_start_addr,
  output logic [31:0]                   dn_start_len,
  input  logic                          burst_done,
  input  logic [8:0]                    burst_beats,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned LEN_W      = 32;
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W      = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(ORDER_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     win_idx;
  logic [LEN_W-1:0]     consumed;

  logic [IDX_W-1:0]     fifo_idx [ORDER_DEPTH];
  logic [LEN_W-1:0]     fifo_len [ORDER_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 grant_c;
  logic [IDX_W-1:0]     rr_nxt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_c;
  logic                 pop_c;
  logic                 overrun_c;
  logic                 stray_c;
  logic [IDX_W-1:0]     head_idx;
  logic [LEN_W-1:0]     head_len;
  logic [LEN_W-1:0]     burst_bytes;
  logic [LEN_W:0]       sum;
  logic [CNT_W-1:0]     count_nxt;
  logic                 issue_nxt;
  logic [NUM_REQ-1:0]   done_c;

  // Wrap-around increment for order FIFO pointers
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ORDER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr, ascending with wrap to 0
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Grant, FIFO push/pop and completion decode
  always_comb begin
    fifo_full   = (count == CNT_W'(ORDER_DEPTH));
    fifo_empty  = (count == '0);
    grant_c     = (state == IDLE) && (req_ready == '0) && !fifo_full && sel_found;
    rr_nxt      = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    push_c      = (state == ISSUE) && dn_start_ready;
    head_idx    = fifo_idx[rd_ptr];
    head_len    = fifo_len[rd_ptr];
    burst_bytes = 32'(burst_beats) * 32'(BEAT_BYTES);
    sum         = 33'(consumed) + 33'(burst_bytes);
    stray_c     = burst_done && fifo_empty;
    pop_c       = burst_done && !fifo_empty && (sum >= 33'(head_len));
    overrun_c   = burst_done && !fifo_empty && (sum > 33'(head_len));
    count_nxt   = count + CNT_W'(push_c) - CNT_W'(pop_c);
    issue_nxt   = ((state == IDLE) && (req_ready != '0) && (dn_start_len != '0)) ||
                  ((state == ISSUE) && !dn_start_ready);
    done_c      = '0;
    if ((state == IDLE) && (req_ready != '0) && (dn_start_len == '0)) done_c = req_ready;
    if (pop_c) done_c = done_c | (NUM_REQ'(1) << head_idx);
  end

  // Control FSM, arbitration state, latched request and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      win_idx        <= '0;
      consumed       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      req_ready      <= '0;
      req_done       <= '0;
      dn_start_valid <= 1'b0;
      dn_start_addr  <= '0;
      dn_start_len   <= '0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      req_ready <= '0;
      req_done  <= done_c;
      busy      <= issue_nxt || (count_nxt != '0);
      count     <= count_nxt;

      if (grant_c) begin
        req_ready     <= NUM_REQ'(1) << sel_idx;
        win_idx       <= sel_idx;
        dn_start_addr <= req_addr[32'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        dn_start_len  <= req_len[32'(sel_idx) * LEN_W +: LEN_W];
        rr_ptr        <= rr_nxt;
      end

      case (state)
        IDLE: begin
          if ((req_ready != '0) && (dn_start_len != '0)) begin
            state          <= ISSUE;
            dn_start_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (dn_start_ready) begin
            state          <= IDLE;
            dn_start_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (push_c) wr_ptr <= ptr_inc(wr_ptr);

      if (pop_c) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        consumed <= '0;
      end else if (burst_done && !fifo_empty) begin
        consumed <= sum[LEN_W-1:0];
      end

      if (stray_c || overrun_c) err <= 1'b1;
    end
  end

  // Order FIFO payload storage; validity is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_idx[wr_ptr] <= win_idx;
      fifo_len[wr_ptr] <= dn_start_len;
    end
  end

endmodule

// File: tb/tb_rd_req_arb.sv
// Directed bench for rd_req_arb with default parameters (BEAT_BYTES = 32).
module tb_rd_req_arb;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_addr;
  logic [127:0] req_len;
  logic         dn_start_valid;
  logic         dn_start_ready;
  logic [63:0]  dn_start_addr;
  logic [31:0]  dn_start_len;
  logic         burst_done;
  logic [8:0]   burst_beats;
  logic [3:0]   req_done;
  logic         busy;
  logic         err;

  int checks;
  int passed;

  rd_req_arb dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .dn_start_valid (dn_start_valid),
    .dn_start_ready (dn_start_ready),
    .dn_start_addr  (dn_start_addr),
    .dn_start_len   (dn_start_len),
    .burst_done     (burst_done),
    .burst_beats    (burst_beats),
    .req_done       (req_done),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and follow it through grant and downstream handshake
  task automatic issue(input int idx, input logic [31:0] len, input logic [63:0] addr,
                       output bit ok);
    ok = 1'b0;
    req_addr[idx*64 +: 64] = addr;
    req_len[idx*32 +: 32]  = len;
    req_valid[idx]         = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid[idx] = 1'b0;
    if (ok) begin
      if (len != 0) repeat (2) @(negedge clk);
      else @(negedge clk);
    end
  endtask

  task automatic burst(input logic [8:0] beats);
    burst_done  = 1'b1;
    burst_beats = beats;
    @(negedge clk);
    burst_done  = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({req_ready, req_done, dn_start_valid, dn_start_addr, dn_start_len, busy, err} !== '0)
      $display("FAIL reset_outputs: ready=%b done=%b dv=%b addr=%h len=%h busy=%b err=%b, want all 0",
               req_ready, req_done, dn_start_valid, dn_start_addr, dn_start_len, busy, err);
    else passed++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_round_robin;
    dn_start_ready = 1'b1;
    req_addr[0*64 +: 64] = 64'h100; req_len[0*32 +: 32] = 32;
    req_addr[2*64 +: 64] = 64'h300; req_len[2*32 +: 32] = 32;
    req_addr[3*64 +: 64] = 64'h400; req_len[3*32 +: 32] = 32;
    req_valid = 4'b0101;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL rr_first: ready=%b want 0001", req_ready);
    else passed++;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (dn_start_valid !== 1'b1 || dn_start_addr !== 64'h100 || busy !== 1'b1)
      $display("FAIL rr_issue0: dv=%b addr=%h busy=%b want 1/100/1", dn_start_valid, dn_start_addr, busy);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) $display("FAIL rr_second: ready=%b want 0100", req_ready);
    else passed++;
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) $display("FAIL rr_ptr_at_3: ready=%b want 1000", req_ready);
    else passed++;
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    burst(9'd1);
    checks++;
    if (req_done !== 4'b0001) $display("FAIL rr_done0: done=%b want 0001", req_done);
    else passed++;
    burst(9'd1);
    checks++;
    if (req_done !== 4'b0100) $display("FAIL rr_done2: done=%b want 0100", req_done);
    else passed++;
    burst(9'd1);
    checks++;
    if (req_done !== 4'b1000 || busy !== 1'b0)
      $display("FAIL rr_done3: done=%b busy=%b want 1000/0", req_done, busy);
    else passed++;
  endtask

  task automatic test_stall;
    int  vcnt;
    bit  stable;
    vcnt   = 0;
    stable = 1'b1;
    dn_start_ready = 1'b0;
    req_addr[1*64 +: 64] = 64'h1000;
    req_len[1*32 +: 32]  = 2048;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL stall_grant: ready=%b want 0010", req_ready);
    else passed++;
    req_valid = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (dn_start_valid) begin
        vcnt++;
        if (dn_start_addr !== 64'h1000 || dn_start_len !== 32'd2048) stable = 1'b0;
      end
      if (k == 5) dn_start_ready = 1'b1;
    end
    checks++;
    if (vcnt !== 6) $display("FAIL stall_valid_cycles: got %0d want 6", vcnt);
    else passed++;
    checks++;
    if (stable !== 1'b1) $display("FAIL stall_stable: addr/len changed while valid");
    else passed++;
    checks++;
    if (busy !== 1'b1 || dn_start_valid !== 1'b0)
      $display("FAIL stall_pushed: busy=%b dv=%b want 1/0", busy, dn_start_valid);
    else passed++;
    burst(9'd64);
    checks++;
    if (req_done !== 4'b0010 || busy !== 1'b0)
      $display("FAIL stall_done: done=%b busy=%b want 0010/0", req_done, busy);
    else passed++;
  endtask

  task automatic test_complete;
    bit ok;
    issue(2, 32'd4096, 64'h2000, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL complete_grant_timeout: ok=%b want 1", ok);
    else passed++;
    burst(9'd64);
    checks++;
    if (req_done !== 4'b0000 || busy !== 1'b1)
      $display("FAIL complete_half: done=%b busy=%b want 0000/1", req_done, busy);
    else passed++;
    burst(9'd64);
    checks++;
    if (req_done !== 4'b0100 || busy !== 1'b0)
      $display("FAIL complete_done: done=%b busy=%b want 0100/0", req_done, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (req_done !== 4'b0000) $display("FAIL complete_pulse_width: done=%b want 0000", req_done);
    else passed++;
  endtask

  task automatic test_fifo_full;
    bit ok;
    bit all_ok;
    bit low;
    logic [3:0] exp_done [4];
    exp_done[0] = 4'b0010; exp_done[1] = 4'b0100; exp_done[2] = 4'b1000; exp_done[3] = 4'b0001;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(i, 32'd64, 64'(32'h5000 + i * 32'h100), ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++;
    if (all_ok !== 1'b1) $display("FAIL full_fill_timeout: ok=%b want 1", all_ok);
    else passed++;
    low = 1'b1;
    req_valid = 4'b0001;
    repeat (5) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) low = 1'b0;
    end
    checks++;
    if (low !== 1'b1) $display("FAIL full_blocks_grant: ready rose while FIFO full");
    else passed++;
    burst(9'd2);
    checks++;
    if (req_done !== 4'b0001) $display("FAIL full_pop: done=%b want 0001", req_done);
    else passed++;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL full_regrant: ready=%b want 0001", req_ready);
    else passed++;
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      burst(9'd2);
      checks++;
      if (req_done !== exp_done[i])
        $display("FAIL full_drain%0d: done=%b want %b", i, req_done, exp_done[i]);
      else passed++;
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) $display("FAIL full_idle: busy=%b err=%b want 0/0", busy, err);
    else passed++;
  endtask

  task automatic test_overrun;
    bit ok;
    issue(1, 32'd32, 64'h6000, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL overrun_grant_timeout: ok=%b want 1", ok);
    else passed++;
    burst(9'd2);
    checks++;
    if (req_done !== 4'b0010 || err !== 1'b1 || busy !== 1'b0)
      $display("FAIL overrun: done=%b err=%b busy=%b want 0010/1/0", req_done, err, busy);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok0;
    bit ok1;
    bit quiet;
    issue(0, 32'd32, 64'h7000, ok0);
    issue(1, 32'd32, 64'h7100, ok1);
    dn_start_ready = 1'b0;
    req_addr[2*64 +: 64] = 64'h7200;
    req_len[2*32 +: 32]  = 32;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (ok0 !== 1'b1 || ok1 !== 1'b1 || dn_start_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL rmid_setup: ok=%b%b dv=%b busy=%b want 11/1/1", ok0, ok1, dn_start_valid, busy);
    else passed++;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({req_ready, req_done, dn_start_valid, dn_start_addr, dn_start_len, busy, err} !== '0)
      $display("FAIL rmid_outputs: ready=%b done=%b dv=%b addr=%h len=%h busy=%b err=%b, want all 0",
               req_ready, req_done, dn_start_valid, dn_start_addr, dn_start_len, busy, err);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    dn_start_ready = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (req_done !== 4'b0000 || busy !== 1'b0 || dn_start_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1 || err !== 1'b0)
      $display("FAIL rmid_after_release: quiet=%b err=%b want 1/0", quiet, err);
    else passed++;
  endtask

  task automatic test_err_and_zero_len;
    bit no_dv;
    burst(9'd1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || req_done !== 4'b0000)
      $display("FAIL stray_burst: err=%b busy=%b done=%b want 1/0/0000", err, busy, req_done);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: err=%b want 1", err);
    else passed++;
    no_dv = 1'b1;
    req_len[3*32 +: 32] = 0;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) $display("FAIL zero_grant: ready=%b want 1000", req_ready);
    else passed++;
    req_valid = 4'b0000;
    @(negedge clk);
    if (dn_start_valid) no_dv = 1'b0;
    checks++;
    if (req_done !== 4'b1000) $display("FAIL zero_done: done=%b want 1000", req_done);
    else passed++;
    repeat (2) begin
      @(negedge clk);
      if (dn_start_valid) no_dv = 1'b0;
    end
    checks++;
    if (no_dv !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_no_issue: no_dv=%b busy=%b want 1/0", no_dv, busy);
    else passed++;
  endtask

  task automatic test_dual_done;
    bit ok;
    issue(0, 32'd32, 64'h8000, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL dual_grant_timeout: ok=%b want 1", ok);
    else passed++;
    req_len[1*32 +: 32] = 0;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) $display("FAIL dual_zero_grant: ready=%b want 0010", req_ready);
    else passed++;
    req_valid   = 4'b0000;
    burst_done  = 1'b1;
    burst_beats = 9'd1;
    @(negedge clk);
    burst_done = 1'b0;
    checks++;
    if (req_done !== 4'b0011 || busy !== 1'b0)
      $display("FAIL dual_done: done=%b busy=%b want 0011/0", req_done, busy);
    else passed++;
  endtask

  initial begin
    checks         = 0;
    passed         = 0;
    rstn           = 1'b1;
    req_valid      = '0;
    req_addr       = '0;
    req_len        = '0;
    dn_start_ready = 1'b0;
    burst_done     = 1'b0;
    burst_beats    = '0;
    test_reset();
    test_round_robin();
    test_stall();
    test_complete();
    test_fifo_full();
    test_overrun();
    test_reset_mid();
    test_err_and_zero_len();
    test_dual_done();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rd_req_arb.md
RD_REQ_ARB -- requirements
Module: rd_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 256, data beat width; BEAT_BYTES = DATA_WIDTH/8.
REQ-004 SHALL have parameter ORDER_DEPTH, default 4, outstanding-request order FIFO depth.
REQ-005 SHALL have ports:
 clk  in  1  sole clock, rising edge.
 rstn  in  1  reset, asynchronous, active-low.
 req_valid  in  NUM_REQ  per-requester request valid.
 req_ready  out  NUM_REQ  per-requester accept, one-hot pulse.
 req_addr  in  NUM_REQ x ADDR_WIDTH  per-requester start byte address.
 req_len  in  NUM_REQ x 32  per-requester length in bytes.
 dn_start_valid  out  1  downstream large-request valid.
 dn_start_ready  in  1  downstream large-request ready.
 dn_start_addr  out  ADDR_WIDTH  downstream start address.
 dn_start_len  out  32  downstream length in bytes.
 burst_done  in  1  one downstream R burst fully received.
 burst_beats  in  9  beats in that burst (1..256).
 req_done  out  NUM_REQ  per-requester completion pulse.
 busy  out  1  high when any request granted or outstanding.
 err  out  1  sticky protocol-error flag.

Function
REQ-006 SHALL implement FSM states IDLE and ISSUE.
REQ-007 In IDLE with order FIFO not full, SHALL select among asserted req_valid by round-robin starting at rr_ptr, ascending index with wrap to 0.
REQ-008 On selection SHALL pulse req_ready[winner] for exactly that cycle and latch winner index, req_addr, and req_len into registers.
REQ-009 If latched req_len == 0, SHALL stay in IDLE, issue nothing downstream, push no FIFO entry, and pulse req_done[winner] on the next cycle.
REQ-010 If latched req_len != 0, SHALL enter ISSUE on the next cycle.
REQ-011 In ISSUE SHALL drive dn_start_valid=1 with dn_start_addr/dn_start_len held stable from the latched registers until dn_start_ready=1.
REQ-012 On the ISSUE handshake cycle SHALL push {index, len} into the order FIFO and return to IDLE; back-to-back grant earliest next cycle.
REQ-013 SHALL set rr_ptr to winner+1 (mod NUM_REQ) on every grant.
REQ-014 SHALL hold all req_ready low when order FIFO is full or state is ISSUE.
REQ-015 SHALL keep a head byte counter consumed (32 bits); on burst_done add burst_beats*BEAT_BYTES.
REQ-016 When consumed + burst bytes == head len, SHALL pulse req_done[head index] the next cycle, pop head, and clear consumed to 0.
REQ-017 When consumed + burst bytes > head len, SHALL set err, pulse req_done[head index], pop head, and clear consumed.
REQ-018 burst_done with order FIFO empty SHALL set err and change no other state.
REQ-019 Simultaneous push (REQ-012) and pop (REQ-016/017) SHALL both take effect; occupancy unchanged.
REQ-020 Order FIFO pointers SHALL wrap modulo ORDER_DEPTH; full = occupancy == ORDER_DEPTH.
REQ-021 Two req_done pulses (REQ-009 and REQ-016) in the same cycle SHALL both assert.
REQ-022 busy SHALL be 1 when state is ISSUE or order FIFO non-empty.
REQ-023 req_len SHALL be a multiple of BEAT_BYTES; otherwise behaviour is undefined, but err SHALL set by REQ-017 when overrun occurs.

Reset
REQ-024 On rstn low, SHALL immediately force: state IDLE, rr_ptr 0, FIFO empty, consumed 0, req_ready 0, req_done 0, dn_start_valid 0, dn_start_addr 0, dn_start_len 0, busy 0, err 0.
REQ-025 Reset mid-ISSUE or with outstanding entries SHALL discard them without any req_done pulse.

Verification
REQ-026 Requesters 0,2 valid, rr_ptr 0, dn_start_ready=1 -> grant 0 then 2 on consecutive grants; rr_ptr ends at 3.
REQ-027 Req 1 addr 0x1000 len 2048, dn_start_ready low 5 cycles -> dn_start_valid held 6 cycles, addr/len stable; entry pushed on handshake.
REQ-028 Len 4096, DATA_WIDTH 256, burst_done beats 64 twice -> req_done[idx] pulse one cycle after second burst_done; FIFO empty; busy 0.
REQ-029 Four len-64 requests, no burst_done, ORDER_DEPTH 4 -> fifth req_ready stays low until a completion pops an entry.
REQ-030 burst_done with empty FIFO -> err=1 sticky; len-0 request -> req_done pulse, no dn_start_valid.
REQ-031 rstn asserted during ISSUE with 2 outstanding -> all outputs 0 same cycle; no req_done after release.
